reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//   Parametrised multi-port register file for the miniMips datapath: 3 combinational
//   read ports, 2 write ports fed from one double-width write bus (hi half / lo half),
//   optional write-to-read forwarding, and a streaming dump engine that serialises the
//   whole file over a valid/ready port for the debug/trace path.
// PARAMETERS
//   DATA_W    8                    register width in bits
//   NUM_REGS  4                    number of registers (>=2)
//   ADDR_W    $clog2(NUM_REGS)     register address width
//   BYPASS    1                    1 = reads forward same-cycle write data; 0 = reads see stored value
// PORTS
//   clk          in   1         clock; all state updates on rising edge
//   reset_n      in   1         asynchronous, active-low reset
//   read_reg1/2/3  in ADDR_W    read addresses
//   read_data1/2/3 out DATA_W   read data
//   write_reg1   in   ADDR_W    write port 1 address
//   write_reg2   in   ADDR_W    write port 2 address
//   write_data   in   2*DATA_W  [2*DATA_W-1:DATA_W] -> port 1, [DATA_W-1:0] -> port 2
//   write_en1    in   1         write enable, port 1
//   write_en2    in   1         write enable, port 2
//   dump_start   in   1         1-cycle request to stream all registers
//   dump_busy    out  1         dump in progress
//   dump_valid   out  1         dump beat valid
//   dump_ready   in   1         consumer accepts beat
//   dump_addr    out  ADDR_W    register index of current beat
//   dump_data    out  DATA_W    register value of current beat
//   dump_last    out  1         current beat is index NUM_REGS-1
// BEHAVIOUR
//   Reset (reset_n=0, async): all registers 0; FSM IDLE; dump_busy/valid/last=0,
//     dump_addr=0, dump_data=0; read_data* = 0 (array zero). Reset mid-dump aborts it.
//   Writes: on rising edge, port 1 writes hi half, port 2 writes lo half when enabled.
//     Both enabled, same address: port 2 (lo half) wins. Addresses >= NUM_REGS ignored.
//   Reads: combinational. Addr >= NUM_REGS returns 0. BYPASS=1: if read addr equals an
//     enabled write addr this cycle, return that write data (port 2 priority on double
//     hit); BYPASS=0: return stored value (new value visible the cycle after the edge).
//   Dump FSM, states IDLE, DUMP; internal index counter idx (ADDR_W bits).
//     IDLE: dump_start=1 at edge -> DUMP, idx=0, dump_data captured = reg[0].
//     DUMP: dump_busy=dump_valid=1, dump_addr=idx, dump_last=(idx==NUM_REGS-1).
//       Transfer = dump_valid & dump_ready at edge. On transfer, not last: idx+1, capture
//       reg[idx+1]. On transfer of last beat: -> IDLE, valid/busy/last drop next cycle.
//       No transfer: all dump outputs held stable (capture register, not live array).
//     Capture value = post-edge register value, i.e. a write landing on that register
//       at the capture edge is included (same port-2 priority).
//     dump_start while DUMP is ignored (no restart, no queueing).
//     Throughput 1 beat/cycle with dump_ready held 1: NUM_REGS valid cycles total.
//   Register writes and reads are never stalled by the dump engine.
// TESTING
//   1. Reset: drive reset_n=0 mid-cycle with regs nonzero -> all read_data*=0 and dump
//      outputs 0 immediately, without a clock edge.
//   2. write_en1=write_en2=1, write_reg1=1, write_reg2=2, write_data=16'hA55A ->
//      next cycle reg1=8'hA5, reg2=8'h5A; same-address (both 3) -> reg3=8'h5A.
//   3. BYPASS=1: write reg0=8'h77 with read_reg1=0 same cycle -> read_data1=8'h77 that
//      cycle; BYPASS=0 -> old value that cycle, 8'h77 next cycle.
//   4. Regs {11,22,33,44}, dump_start pulse, dump_ready=1 -> beats addr 0..3 data
//      11,22,33,44 on 4 consecutive cycles, dump_last on addr 3, then busy=0.
//   5. Backpressure: dump_ready=0 for 3 cycles on beat 1 while writing reg1=8'hEE ->
//      dump_data stays 22 until accepted; dump_start during dump ignored.
//   6. NUM_REGS=6, DATA_W=16: read/write addr 7 -> read 0, no write; full dump 6 beats.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised multi-port register file with three combinational read ports, a split
// double-width write bus and a valid/ready dump engine that streams the whole file.
module reg_file_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     read_reg1,
    input  logic [ADDR_W-1:0]     read_reg2,
    input  logic [ADDR_W-1:0]     read_reg3,
    output logic [DATA_W-1:0]     read_data1,
    output logic [DATA_W-1:0]     read_data2,
    output logic [DATA_W-1:0]     read_data3,
    input  logic [ADDR_W-1:0]     write_reg1,
    input  logic [ADDR_W-1:0]     write_reg2,
    input  logic [2*DATA_W-1:0]   write_data,
    input  logic                  write_en1,
    input  logic                  write_en2,
    input  logic                  dump_start,
    output logic                  dump_busy,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_W-1:0]     dump_addr,
    output logic [DATA_W-1:0]     dump_data,
    output logic                  dump_last
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {IDLE, DUMP} state_t;

    logic [DATA_W-1:0] regs      [NUM_REGS];
    logic [DATA_W-1:0] regs_next [NUM_REGS];
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] wdata2;
    logic [ADDR_W-1:0] raddr     [3];
    logic [DATA_W-1:0] rdata     [3];

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;
    logic [DATA_W-1:0] cap;
    logic [DATA_W-1:0] cap_next;
    logic [ADDR_W-1:0] cap_sel;
    logic [DATA_W-1:0] cap_val;

    assign wdata1 = write_data[2*DATA_W-1:DATA_W];
    assign wdata2 = write_data[DATA_W-1:0];

    // Post-edge array image: port 2 overrides port 1, out-of-range addresses match nothing.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_next[i] = regs[i];
            if (write_en1 && (write_reg1 == ADDR_W'(i))) regs_next[i] = wdata1;
            if (write_en2 && (write_reg2 == ADDR_W'(i))) regs_next[i] = wdata2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs_next[i];
        end
    end

    // Forwarding is simply reading the post-edge image instead of the stored array.
    always_comb begin
        raddr[0] = read_reg1;
        raddr[1] = read_reg2;
        raddr[2] = read_reg3;
        for (int p = 0; p < 3; p++) begin
            rdata[p] = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (raddr[p] == ADDR_W'(i)) rdata[p] = (BYPASS != 0) ? regs_next[i] : regs[i];
            end
        end
    end

    assign read_data1 = rdata[0];
    assign read_data2 = rdata[1];
    assign read_data3 = rdata[2];

    // Next register to capture: index 0 on start, idx+1 on an accepted beat.
    always_comb begin
        cap_sel = (state == DUMP) ? idx + ADDR_W'(1) : '0;
        cap_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cap_sel == ADDR_W'(i)) cap_val = regs_next[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            cap   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            cap   <= cap_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cap_next   = cap;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = DUMP;
                    idx_next   = '0;
                    cap_next   = cap_val;
                end
            end
            DUMP: begin
                if (dump_ready) begin
                    if (idx == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                        cap_next   = '0;
                    end else begin
                        idx_next = idx + ADDR_W'(1);
                        cap_next = cap_val;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dump_busy  = 1'b0;
        dump_valid = 1'b0;
        dump_last  = 1'b0;
        dump_addr  = '0;
        if (state == DUMP) begin
            dump_busy  = 1'b1;
            dump_valid = 1'b1;
            dump_addr  = idx;
            dump_last  = (idx == LAST_IDX);
        end
    end

    assign dump_data = cap;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed writes/reads on two configurations, dump beats
// checked by a negedge monitor against a queue of expected beats.
module tb_reg_file_param;

    logic clk;
    logic reset_n;

    // Instance A: defaults (8-bit, 4 regs, forwarding on)
    logic [1:0]  a_rr1, a_rr2, a_rr3, a_wr1, a_wr2, a_addr;
    logic [7:0]  a_rd1, a_rd2, a_rd3, a_data;
    logic [15:0] a_wd;
    logic        a_we1, a_we2, a_start, a_busy, a_valid, a_ready, a_last;

    // Instance B: 16-bit, 6 regs, forwarding off
    logic [2:0]  b_rr1, b_rr2, b_rr3, b_wr1, b_wr2, b_addr;
    logic [15:0] b_rd1, b_rd2, b_rd3, b_data;
    logic [31:0] b_wd;
    logic        b_we1, b_we2, b_start, b_busy, b_valid, b_ready, b_last;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    int checks = 0;
    int errors = 0;

    reg_file_param dut_a (
        .clk(clk), .reset_n(reset_n),
        .read_reg1(a_rr1), .read_reg2(a_rr2), .read_reg3(a_rr3),
        .read_data1(a_rd1), .read_data2(a_rd2), .read_data3(a_rd3),
        .write_reg1(a_wr1), .write_reg2(a_wr2), .write_data(a_wd),
        .write_en1(a_we1), .write_en2(a_we2),
        .dump_start(a_start), .dump_busy(a_busy), .dump_valid(a_valid),
        .dump_ready(a_ready), .dump_addr(a_addr), .dump_data(a_data), .dump_last(a_last)
    );

    reg_file_param #(.DATA_W(16), .NUM_REGS(6), .BYPASS(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .read_reg1(b_rr1), .read_reg2(b_rr2), .read_reg3(b_rr3),
        .read_data1(b_rd1), .read_data2(b_rd2), .read_data3(b_rd3),
        .write_reg1(b_wr1), .write_reg2(b_wr2), .write_data(b_wd),
        .write_en1(b_we1), .write_en2(b_we2),
        .dump_start(b_start), .dump_busy(b_busy), .dump_valid(b_valid),
        .dump_ready(b_ready), .dump_addr(b_addr), .dump_data(b_data), .dump_last(b_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int addr, input int data, input bit last);
        beat_t b;
        b.addr = 3'(addr);
        b.data = 16'(data);
        b.last = last;
        qa.push_back(b);
    endtask

    task automatic push_b(input int addr, input int data, input bit last);
        beat_t b;
        b.addr = 3'(addr);
        b.data = 16'(data);
        b.last = last;
        qb.push_back(b);
    endtask

    // Beat monitor: every accepted beat must match the head of its expected queue.
    always @(negedge clk) begin
        beat_t e;
        if (a_valid && a_ready) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_beat_unexpected actual_addr=%0d required=none", a_addr);
            end else begin
                e = qa.pop_front();
                chk("a_beat_addr", 32'(a_addr), 32'(e.addr));
                chk("a_beat_data", 32'(a_data), 32'(e.data[7:0]));
                chk("a_beat_last", 32'(a_last), 32'(e.last));
            end
        end
        if (b_valid && b_ready) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_beat_unexpected actual_addr=%0d required=none", b_addr);
            end else begin
                e = qb.pop_front();
                chk("b_beat_addr", 32'(b_addr), 32'(e.addr));
                chk("b_beat_data", 32'(b_data), 32'(e.data));
                chk("b_beat_last", 32'(b_last), 32'(e.last));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0;
        {a_rr1, a_rr2, a_rr3, a_wr1, a_wr2, a_wd, a_we1, a_we2, a_start, a_ready} = '0;
        {b_rr1, b_rr2, b_rr3, b_wr1, b_wr2, b_wd, b_we1, b_we2, b_start, b_ready} = '0;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("reset_rd1", 32'(a_rd1), 32'h0);
        chk("reset_busy", 32'(a_busy), 32'h0);
        chk("reset_dump_data", 32'(a_data), 32'h0);

        // Split write bus, then same-address double write
        a_we1 = 1; a_we2 = 1; a_wr1 = 1; a_wr2 = 2; a_wd = 16'hA55A;
        step();
        a_wr1 = 3; a_wr2 = 3; a_wd = 16'h1234; a_rr1 = 1; a_rr2 = 2; a_rr3 = 3;
        #1;
        chk("write_hi_reg1", 32'(a_rd1), 32'hA5);
        chk("write_lo_reg2", 32'(a_rd2), 32'h5A);
        step();
        a_we1 = 0; a_we2 = 0;
        #1;
        chk("same_addr_port2_wins", 32'(a_rd3), 32'h34);

        // Forwarding with double hit on reg0: port 2 data forwarded
        a_we1 = 1; a_we2 = 1; a_wr1 = 0; a_wr2 = 0; a_wd = 16'h6677; a_rr1 = 0;
        #1;
        chk("bypass_same_cycle", 32'(a_rd1), 32'h77);
        chk("bypass_other_port", 32'(a_rd3), 32'h34);
        step();
        a_we1 = 0; a_we2 = 0;
        #1;
        chk("bypass_stored", 32'(a_rd1), 32'h77);

        // Full dump, ready held high
        a_we1 = 1; a_we2 = 1; a_wr1 = 0; a_wr2 = 1; a_wd = 16'h1122;
        step();
        a_wr1 = 2; a_wr2 = 3; a_wd = 16'h3344;
        step();
        a_we1 = 0; a_we2 = 0;
        push_a(0, 'h11, 0); push_a(1, 'h22, 0); push_a(2, 'h33, 0); push_a(3, 'h44, 1);
        a_ready = 1; a_start = 1;
        step();
        a_start = 0;
        n = 0;
        while (a_busy && n < 20) begin
            n++;
            step();
        end
        chk("dump_valid_cycles", 32'(n), 32'd4);
        chk("dump_idle_after", 32'(a_busy), 32'h0);
        chk("dump_queue_drained", 32'(qa.size()), 32'd0);

        // Start with same-edge write to reg0, then backpressure on beat 1
        push_a(0, 'h55, 0); push_a(1, 'h22, 0); push_a(2, 'h33, 0); push_a(3, 'h44, 1);
        a_start = 1; a_we2 = 1; a_wr2 = 0; a_wd = 16'h0055;
        step();
        a_start = 0; a_we2 = 0;
        step();
        a_ready = 0; a_we1 = 1; a_wr1 = 1; a_wd = 16'hEE00; a_start = 1;
        for (int k = 0; k < 3; k++) begin
            chk("hold_data", 32'(a_data), 32'h22);
            chk("hold_addr", 32'(a_addr), 32'h1);
            step();
            a_we1 = 0; a_start = 0;
        end
        a_ready = 1;
        n = 0;
        while (a_busy && n < 20) begin
            n++;
            step();
        end
        chk("bp_queue_drained", 32'(qa.size()), 32'd0);
        step();
        chk("start_in_dump_ignored", 32'(a_busy), 32'h0);
        a_rr2 = 1;
        #1;
        chk("write_during_dump", 32'(a_rd2), 32'hEE);

        // Instance B: no forwarding, out-of-range address, 6-beat dump
        b_we1 = 1; b_we2 = 1; b_wr1 = 1; b_wr2 = 2; b_wd = 32'h1111_2222;
        step();
        b_wr1 = 3; b_wr2 = 4; b_wd = 32'h3333_4444;
        step();
        b_wr1 = 5; b_wr2 = 0; b_wd = 32'h5555_0077; b_rr1 = 0;
        #1;
        chk("nobypass_old", 32'(b_rd1), 32'h0);
        step();
        chk("nobypass_next", 32'(b_rd1), 32'h0077);
        b_wr1 = 7; b_wr2 = 7; b_wd = 32'hBEEF_CAFE; b_rr2 = 7;
        #1;
        chk("oor_read_during_write", 32'(b_rd2), 32'h0);
        step();
        b_we1 = 0; b_we2 = 0;
        #1;
        chk("oor_read", 32'(b_rd2), 32'h0);
        push_b(0, 'h0077, 0); push_b(1, 'h1111, 0); push_b(2, 'h2222, 0);
        push_b(3, 'h3333, 0); push_b(4, 'h4444, 0); push_b(5, 'h5555, 1);
        b_ready = 1; b_start = 1;
        step();
        b_start = 0;
        n = 0;
        while (b_busy && n < 30) begin
            n++;
            step();
        end
        chk("b_dump_valid_cycles", 32'(n), 32'd6);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);

        // Asynchronous reset in the middle of a dump
        push_a(0, 'h55, 0); push_a(1, 'hEE, 0); push_a(2, 'h33, 0); push_a(3, 'h44, 1);
        a_rr1 = 0; a_rr2 = 1; a_rr3 = 3; b_rr1 = 1;
        a_start = 1;
        step();
        a_start = 0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_valid", 32'(a_valid), 32'h0);
        chk("rst_last", 32'(a_last), 32'h0);
        chk("rst_addr", 32'(a_addr), 32'h0);
        chk("rst_data", 32'(a_data), 32'h0);
        chk("rst_rd1", 32'(a_rd1), 32'h0);
        chk("rst_rd2", 32'(a_rd2), 32'h0);
        chk("rst_rd3", 32'(a_rd3), 32'h0);
        chk("rst_b_rd1", 32'(b_rd1), 32'h0);
        qa.delete();
        step();
        reset_n = 1'b1;
        a_ready = 0;
        step();
        chk("post_reset_idle", 32'(a_busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
